stream_mux_rr: RTL

- Parametrised N-channel registered stream multiplexer with valid/ready handshake on every input and on the output.
- Successor to the team's combinational 2:1 muxes. Adds channel count, a fixed-select or round-robin mode, a blanking (force-zero) option and one output register stage.
- Sits between multiple data producers and a single downstream consumer in the datapath.

---
 rtl/mux_pkg.sv | 12 +
 rtl/stream_mux_rr_if.sv | 29 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/stream_mux_rr.sv | 101 ++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered stream multiplexer.
// Imported by the interface, the arbiter and the top level.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N producers, the mux and one consumer.
// slave is the mux side, master the producer/consumer side.
interface stream_mux_rr_if
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 32,
  localparam int CH_W   = clog2_min1(NUM_CH)
);

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i,
// wrapping modulo NUM_CH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic              gnt_valid_o,
  output logic [CH_W-1:0]   gnt_idx_o
);

  // Scan farthest-first so the nearest requester is written last.
  always_comb begin
    int idx;
    idx         = 0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(ptr_i) + i) % NUM_CH;
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux, fixed-select or round-robin,
// with optional data blanking and one output register stage.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 32,
  localparam int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode_i,
  input  logic [CH_W-1:0] sel_i,
  input  logic            blank_i,
  stream_mux_rr_if.slave  bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;

  logic             load;
  logic             rr_gv;
  logic [CH_W-1:0]  rr_g;
  logic             fix_gv;
  logic             gv;
  logic [CH_W-1:0]  g;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req_i       (bus.in_valid),
    .ptr_i       (ptr_q),
    .gnt_valid_o (rr_gv),
    .gnt_idx_o   (rr_g)
  );

  assign load   = !out_valid_q || bus.out_ready;
  assign fix_gv = (int'(sel_i) < NUM_CH) && bus.in_valid[sel_i];

  always_comb begin
    gv = 1'b0;
    g  = '0;
    unique case (mode_i)
      MODE_FIXED: begin
        gv = fix_gv;
        g  = sel_i;
      end
      MODE_RR: begin
        gv = rr_gv;
        g  = rr_g;
      end
    endcase
  end

  // Held low in reset: a handshake there would be lost.
  always_comb begin
    bus.in_ready = '0;
    if (!rst && load && gv) begin
      bus.in_ready[g] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gv) begin
        out_valid_d = 1'b1;
        out_ch_d    = g;
        ptr_d       = g;
        out_data_d  = blank_i ? '0
                    : bus.in_data[int'(g)*WIDTH +: WIDTH];
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= CH_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule
